// File: rtl/simon_key_unroll.sv
// simon_key_unroll
//   Reverse key-schedule generator for SIMON64/128 (N=32, M=4, T=44).
//   Given any window of four consecutive round keys k[s..s+3], it regenerates
//   k[s-1], k[s-2], ... k[0], newest first, one key per cycle on a
//   valid/ready stream. Decryption can therefore walk the schedule backwards
//   from the final window without holding all 44 words.
//
// Ports
//   clk        in   1    clock
//   rst        in   1    synchronous reset, active-high
//   load       in   1    start request, sampled only while idle
//   key_in     in   N*M  window {k[s+3],k[s+2],k[s+1],k[s]} (MSW = newest)
//   start_idx  in   8    s, index of the oldest word in key_in
//   out_valid  out  1    out_key is valid
//   out_ready  in   1    consumer accepts out_key
//   out_key    out  N    regenerated round key k[j]
//   out_idx    out  8    j
//   out_last   out  1    high with out_valid when j == 0
//   busy       out  1    high while keys are being produced
//   bad_start  out  1    one-cycle pulse on a rejected load
module simon_key_unroll #(
    parameter int          N     = 32,
    parameter int          M     = 4,
    parameter int          T     = 44,
    parameter logic [61:0] Z_SEQ = 62'b11110000101100111001010001001000000111101001100011010111011011
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N*M-1:0] key_in,
    input  logic [7:0]     start_idx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_key,
    output logic [7:0]     out_idx,
    output logic           out_last,
    output logic           busy,
    output logic           bad_start
);

    localparam logic [7:0] MAX_START = 8'(T - M);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Window registers hold k[j+1], k[j+2], k[j+3] for the key currently on
    // out_key. k[j+4] is never stored: after a shift it is the old w3, and at
    // load time it comes straight from key_in.
    logic [N-1:0] w1;
    logic [N-1:0] w2;
    logic [N-1:0] w3;

    logic start_ok;
    logic do_load;
    logic reject;
    logic advance;

    // One inverse key-expansion step: recovers k[j] from k[j+1], k[j+3], k[j+4].
    function automatic logic [N-1:0] inv_step(
        input logic [N-1:0] k1,
        input logic [N-1:0] k3,
        input logic [N-1:0] k4,
        input logic [7:0]   j
    );
        logic [N-1:0] tmp;
        logic [5:0]   zi;
        tmp = {k3[2:0], k3[N-1:3]} ^ k1;
        tmp = tmp ^ {tmp[0], tmp[N-1:1]};
        zi  = (j >= 8'd62) ? 6'(j - 8'd62) : j[5:0];
        // ~k4 ^ 3 folded into a single constant; the z bit lands on bit 0 only.
        inv_step = k4 ^ tmp ^ {{(N-2){1'b1}}, 2'b00} ^ {{(N-1){1'b0}}, Z_SEQ[zi]};
    endfunction

    assign start_ok  = (start_idx != 8'd0) && (start_idx <= MAX_START);
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_last  = out_valid && (out_idx == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // out_valid is high for the whole of RUN, so a handshake is simply
    // out_ready while running.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        reject     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    if (start_ok) begin
                        do_load    = 1'b1;
                        state_next = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (out_idx == 8'd0) begin
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            out_key   <= '0;
            out_idx   <= '0;
            bad_start <= 1'b0;
        end else begin
            bad_start <= reject;
            if (do_load) begin
                w1      <= key_in[N-1:0];
                w2      <= key_in[2*N-1:N];
                w3      <= key_in[3*N-1:2*N];
                out_idx <= start_idx - 8'd1;
                out_key <= inv_step(key_in[N-1:0], key_in[3*N-1:2*N],
                                    key_in[4*N-1:3*N], start_idx - 8'd1);
            end else if (advance) begin
                // Shift the window down by one: the key just accepted becomes k[j+1].
                w1      <= out_key;
                w2      <= w1;
                w3      <= w2;
                out_idx <= out_idx - 8'd1;
                out_key <= inv_step(out_key, w2, w3, out_idx - 8'd1);
            end
        end
    end

endmodule
